// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the write-back data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } cacheStateT;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  function automatic int offBits(input int blockWords);
    return $clog2(blockWords) + 2;
  endfunction

  function automatic int idxBits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagBits(input int sets, input int blockWords);
    return 32 - offBits(blockWords) - idxBits(sets);
  endfunction

endpackage

// File: rtl/cache_arrays.sv
// Direct-mapped line storage: valid/dirty bits (cleared by reset), tags and data words.
module cache_arrays
  import cache_pkg::*;
#(
  parameter int SETS        = 64,
  parameter int BLOCK_WORDS = 4,
  localparam int IDX        = idxBits(SETS),
  localparam int TAGW       = tagBits(SETS, BLOCK_WORDS),
  localparam int WSEL       = $clog2(BLOCK_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX-1:0]               index,
  output logic                         rdValid,
  output logic                         rdDirty,
  output logic [TAGW-1:0]              rdTag,
  output logic [BLOCK_WORDS-1:0][31:0] rdLine,
  input  logic                         wordWe,
  input  logic [WSEL-1:0]              wordSel,
  input  logic [31:0]                  wordData,
  input  logic                         metaWe,
  input  logic [TAGW-1:0]              metaTag,
  input  logic                         metaValid,
  input  logic                         metaDirty
);

  logic [SETS-1:0]              validBits;
  logic [SETS-1:0]              dirtyBits;
  logic [TAGW-1:0]              tagMem  [SETS];
  logic [BLOCK_WORDS-1:0][31:0] dataMem [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validBits <= '0;
      dirtyBits <= '0;
    end else if (metaWe) begin
      validBits[index] <= metaValid;
      dirtyBits[index] <= metaDirty;
    end
  end

  // Tags and data carry no reset; a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (metaWe) tagMem[index] <= metaTag;
    if (wordWe) dataMem[index][wordSel] <= wordData;
  end

  assign rdValid = validBits[index];
  assign rdDirty = dirtyBits[index];
  assign rdTag   = tagMem[index];
  assign rdLine  = dataMem[index];

endmodule

// File: rtl/dcache_wb.sv
// Write-back, write-allocate direct-mapped data cache controller with a word-serial memory port.
module dcache_wb
  import cache_pkg::*;
#(
  parameter int SETS        = 64,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        Mem_Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OFF  = offBits(BLOCK_WORDS);
  localparam int IDX  = idxBits(SETS);
  localparam int TAGW = tagBits(SETS, BLOCK_WORDS);
  localparam int WSEL = $clog2(BLOCK_WORDS);
  localparam logic [WSEL-1:0] LAST_WORD = WSEL'(BLOCK_WORDS - 1);

  cacheStateT                   state;
  logic [WSEL-1:0]              count;
  logic [WSEL-1:0]              cpuWord;
  logic [IDX-1:0]               cpuIndex;
  logic [TAGW-1:0]              cpuTag;
  logic                         unusedAddrBits;
  logic                         access;
  logic                         hit;
  logic                         miss;
  logic                         lastWord;
  logic                         rdValid;
  logic                         rdDirty;
  logic [TAGW-1:0]              rdTag;
  logic [BLOCK_WORDS-1:0][31:0] rdLine;
  logic                         wordWe;
  logic [WSEL-1:0]              wordSel;
  logic [31:0]                  wordData;
  logic                         metaWe;
  logic                         metaDirty;

  assign cpuWord        = cpu_addr[OFF-1:2];
  assign cpuIndex       = cpu_addr[OFF+IDX-1:OFF];
  assign cpuTag         = cpu_addr[31:OFF+IDX];
  assign unusedAddrBits = ^cpu_addr[1:0];

  assign access   = cpu_read | cpu_write;
  assign hit      = access & rdValid & (rdTag == cpuTag);
  assign miss     = access & ~hit;
  assign lastWord = (count == LAST_WORD);

  cache_arrays #(
    .SETS       (SETS),
    .BLOCK_WORDS(BLOCK_WORDS)
  ) uArrays (
    .clk      (clk),
    .rst      (rst),
    .index    (cpuIndex),
    .rdValid  (rdValid),
    .rdDirty  (rdDirty),
    .rdTag    (rdTag),
    .rdLine   (rdLine),
    .wordWe   (wordWe),
    .wordSel  (wordSel),
    .wordData (wordData),
    .metaWe   (metaWe),
    .metaTag  (cpuTag),
    .metaValid(1'b1),
    .metaDirty(metaDirty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            count <= '0;
            state <= (rdValid && rdDirty) ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            if (lastWord) begin
              count <= '0;
              state <= REFILL;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            if (lastWord) begin
              count <= '0;
              state <= IDLE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback addresses come from the victim tag still held in the set; refill uses the core's tag.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = MEM_CMD_READ;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = MEM_CMD_WRITE;
        mem_addr  = {rdTag, cpuIndex, count, 2'b00};
        mem_wdata = rdLine[count];
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {cpuTag, cpuIndex, count, 2'b00};
      end
      default: ;
    endcase
  end

  always_comb begin
    wordWe    = 1'b0;
    wordSel   = cpuWord;
    wordData  = cpu_wdata;
    metaWe    = 1'b0;
    metaDirty = 1'b0;
    if (state == REFILL) begin
      wordWe   = mem_ack;
      wordSel  = count;
      wordData = mem_rdata;
      metaWe   = mem_ack & lastWord;
    end else if (state == IDLE && hit && cpu_write) begin
      wordWe    = 1'b1;
      metaWe    = 1'b1;
      metaDirty = 1'b1;
    end
  end

  assign cpu_rdata = rdLine[cpuWord];
  assign Mem_Stall = (state != IDLE) | miss;

endmodule

// File: doc/dcache_wb.md
# dcache_wb

Parametrised write-back, write-allocate, direct-mapped data cache controller between the pipelined core's memory stage and a word-serial main-memory port. It resolves core loads and stores to cache hits with zero stall. On a miss it raises `Mem_Stall` while it writes back a dirty victim line and refills the missing line. Geometry (sets, words per line) is set by parameters, replacing the fixed external stall source the core top receives today.

## Interface
- `SETS`, 64: number of lines. Power of two, ≥2.
- `BLOCK_WORDS`, 4: 32-bit words per line. Power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_read`  in  1  M-stage load request (core `MemReadM`).
- `cpu_write`  in  1  M-stage store request (core `MemWriteM`).
- `cpu_addr`  in  32  byte address (core `ALUoutM`); bits [1:0] are ignored.
- `cpu_wdata`  in  32  store data (core `RD2_Reg_File_aft_muxM`).
- `cpu_rdata`  out  32  load data (core `Mem_RDM`).
- `Mem_Stall`  out  1  freezes the core pipeline.
- `mem_req`  out  1  memory word request; held until `mem_ack`.
- `mem_we`  out  1  1 = write (writeback), 0 = read (refill).
- `mem_addr`  out  32  word-aligned memory address.
- `mem_wdata`  out  32  writeback data.
- `mem_rdata`  in  32  refill data; valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1  word accepted/returned. Ignored while `mem_req`=0.

## Operation
- Address split:
  - OFF = log2(BLOCK_WORDS) + 2
  - IDX = log2(SETS)
  - word = addr[OFF-1:2]
  - index = addr[OFF+IDX-1:OFF]
  - tag = addr[31:OFF+IDX]
- Storage per line: valid, dirty, tag, BLOCK_WORDS data words.
  - Valid and dirty are cleared by reset.
  - Tag and data are not reset.
- `hit` = (`cpu_read` | `cpu_write`) & valid[index] & (tag[index] == tag).
- If both `cpu_read` and `cpu_write` are high, the access is treated as a write.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE:
  - Read hit: `cpu_rdata` = addressed word (combinational).
  - Write hit: the word is written at the edge and dirty[index] is set.
  - Miss with a dirty valid victim: go to WRITEBACK.
  - Miss otherwise: go to REFILL.
  - The word counter is cleared on leaving IDLE.
- WRITEBACK:
  - `mem_req`=1, `mem_we`=1.
  - `mem_addr` = {victim tag, index, count, 2'b00}; `mem_wdata` = victim word[count].
  - On `mem_ack`, count increments.
  - On ack of the last word: count←0, go to REFILL.
- REFILL:
  - `mem_req`=1, `mem_we`=0.
  - `mem_addr` = {cpu tag, index, count, 2'b00}.
  - On `mem_ack`, word[count]←`mem_rdata` and count increments.
  - On the last ack: tag←cpu tag, valid←1, dirty←0, go to IDLE.
  - The retried access then hits in IDLE. A store completes there and sets dirty.
- `Mem_Stall` = (state≠IDLE) | ((`cpu_read`|`cpu_write`) & ~hit). It is combinational.
- Outside WRITEBACK/REFILL: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- While `Mem_Stall`=1 the core holds `cpu_*` stable. The controller behaviour is undefined if they change.

## Timing
- Reset values (asynchronous, `rst`=0):
  - state=IDLE, count=0, all valid/dirty=0.
  - `mem_req`=0, `mem_we`=0, `Mem_Stall`=0 (no request present).
  - `cpu_rdata` = array word; don't-care unless a hit occurs.
- Hit latency: 0 stall cycles; read data is valid in the same cycle.
- Clean miss, `mem_ack` in every request cycle: `Mem_Stall` high for 1+BLOCK_WORDS cycles.
- Dirty miss, same ack timing: 1+2·BLOCK_WORDS stall cycles.
- Each extra wait cycle before an ack adds one stall cycle. `mem_addr`/`mem_we`/`mem_wdata` stay constant until the ack.
- Count wraps only by the explicit clear on the last word. No partial-line transfers.
- Reset asserted mid-burst:
  - `mem_req` drops immediately and the FSM returns to IDLE.
  - The partially refilled line stays invalid.
  - Memory must drop any outstanding request on the same reset.

## Structure
- Package `cache_pkg`:
  - state enum (IDLE, WRITEBACK, REFILL);
  - functions deriving OFF/IDX/TAG widths from the parameters;
  - the memory-port command constants.
- One sub-module, `cache_arrays`. It holds the tag/valid/dirty/data storage, with:
  - combinational read of a set;
  - a single write port for a word;
  - a line-metadata update port;
  - asynchronous active-low clear of valid/dirty.
- The FSM, counter and address muxing live in `dcache_wb`.

## Test plan
Defaults SETS=64, BLOCK_WORDS=4 (index=addr[9:4], tag=addr[31:10]); ack every cycle unless stated.
- Cold read miss, then hits:
  - Stimulus: after reset, read 0x100; memory returns 0xA0,0xA1,0xA2,0xA3.
  - Response: `Mem_Stall` high 5 cycles; `mem_addr` 0x100/0x104/0x108/0x10C; then `cpu_rdata`=0xA0 with stall low.
  - Follow-up: read 0x104 → 0 stall, 0xA1, no `mem_req`.
- Write hit:
  - Stimulus: write 0x108 with 0xDEADBEEF.
  - Response: 0 stall, no `mem_req`; a read of 0x108 returns 0xDEADBEEF.
- Dirty conflict miss:
  - Stimulus: read 0x500 (index 0x10, new tag).
  - Response: writeback of 0xA0,0xA1,0xDEADBEEF,0xA3 to 0x100–0x10C with `mem_we`=1, then refill of 0x500–0x50C; 9 stall cycles.
- Slow memory:
  - Stimulus: ack only after 3 idle cycles per word.
  - Response: request outputs held stable; a clean miss gives 1+4·4=17 stall cycles.
- Write miss:
  - Stimulus: write 0x2000 with 0x55.
  - Response: refill of 0x2000–0x200C, then the store completes; a later conflicting miss writes back 0x55 at 0x2000.
- Reset mid-refill:
  - Stimulus: drop `rst` after 2 refill acks.
  - Response: `mem_req`=0 and `Mem_Stall`=0 immediately; re-reading the same address misses with a full 4-word refill.
